// File: rtl/sram_like_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_pkg
// Brief   : Shared definitions for the SRAM-like data port: transfer size
//           encodings, response-age width, stall LFSR seed and the
//           byte-enable decoder.
// Rev     : 1.0  initial release
// ============================================================================
package sram_like_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  // Ages only need to reach LATENCY (at most 4).
  localparam int          c_AGE_W     = 3;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  // Byte lanes touched by a write; misaligned low address bits are ignored
  // for half/word and the reserved size writes nothing.
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sram_resp_fifo
// Brief   : In-order response queue. Each entry carries its response data
//           and an age that starts at 1 on push (the accept cycle counts)
//           and saturates at SAT_AGE.
// Rev     : 1.0  initial release
// ============================================================================
module sram_resp_fifo
  import sram_like_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 32,
  parameter int SAT_AGE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_push_data,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [DATA_W-1:0]  o_head_data,
  output logic [c_AGE_W-1:0] o_head_age
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_AGE_W-1:0] c_SAT   = c_AGE_W'(SAT_AGE);

  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [c_AGE_W-1:0] r_age  [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;
  logic [c_PTR_W-1:0] w_wr_ptr_nxt;
  logic [c_CNT_W-1:0] r_count;

  assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
  assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);

  assign o_full      = (r_count == c_CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_age  = r_age[r_rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (i_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-slot ages: restart at 1 on push, otherwise count up to saturation.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst) begin
        r_age[i] <= '0;
      end else if (i_push && (r_wr_ptr == c_PTR_W'(i))) begin
        r_age[i] <= c_AGE_W'(1);
      end else if (r_age[i] < c_SAT) begin
        r_age[i] <= r_age[i] + c_AGE_W'(1);
      end
    end
  end

  // Response payload store; contents are don't-care while a slot is free.
  always_ff @(posedge clk) begin
    if (i_push) r_data[r_wr_ptr] <= i_push_data;
  end

endmodule
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_sram_responder
// Brief   : SRAM-like data-port target backed by an internal word array.
//           Requests are accepted and performed in the accept cycle; the
//           response (read word or 0) is queued and returned in order after
//           LATENCY cycles. Optional macro DATA_SRAM_STALL_EN adds an LFSR
//           that randomly blocks acceptance and retirement.
// Rev     : 1.0  initial release
// ============================================================================
module data_sram_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int                 c_WORDS = 1 << ADDR_WIDTH;
  localparam logic [c_AGE_W-1:0] c_LAT   = c_AGE_W'(LATENCY);

  logic [31:0]           r_mem [c_WORDS];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_full;
  logic                  w_empty;
  logic [31:0]           w_head_data;
  logic [c_AGE_W-1:0]    w_head_age;
  logic [31:0]           w_resp_data;
  logic                  w_stall_acc;
  logic                  w_stall_ret;
  logic                  w_unused;

`ifdef DATA_SRAM_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 driving pseudo-random back-pressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= c_LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall_acc = r_lfsr[0];
  assign w_stall_ret = r_lfsr[1];
`else
  assign w_stall_acc = 1'b0;
  assign w_stall_ret = 1'b0;
`endif

  // Upper address bits alias onto the array without any fault.
  assign w_idx    = data_addr[ADDR_WIDTH+1:2];
  assign w_unused = &{1'b0, data_addr[31:ADDR_WIDTH+2]};

  // Retirement and acceptance depend only on queue state (and reset/stall),
  // so a full queue can take a new request in the cycle its head leaves.
  assign w_retire     = rst && !w_empty && (w_head_age >= c_LAT) && !w_stall_ret;
  assign data_addr_ok = rst && !w_stall_acc && (!w_full || w_retire);
  assign w_accept     = data_req && data_addr_ok;

  assign data_data_ok = w_retire;
  assign data_rdata   = w_retire ? w_head_data : 32'h0;

  // Reads capture the word before any later write; writes respond with 0.
  assign w_resp_data = data_wr ? 32'h0 : r_mem[w_idx];
  assign w_be        = data_wr ? byte_en(data_size, data_addr[1:0]) : 4'b0000;

  // Byte-lane array update; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH   (OUTSTANDING),
    .DATA_W  (32),
    .SAT_AGE (LATENCY)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_accept),
    .i_push_data (w_resp_data),
    .i_pop       (w_retire),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_data (w_head_data),
    .o_head_age  (w_head_age)
  );

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits of internal array (4 KiB).
REQ-002 SHALL have parameter LATENCY, default 1, legal 1..4, cycles from accept to data_ok.
REQ-003 SHALL have parameter OUTSTANDING, default 2, legal 1..4, maximum accepted-but-unanswered requests.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  one clock; reset is synchronous and active-low.
REQ-006 SHALL have port data_req  input  1  initiator request valid.
REQ-007 SHALL have port data_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port data_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port data_addr  input  32  byte address.
REQ-010 SHALL have port data_wdata  input  32  write data, lane-replicated by initiator.
REQ-011 SHALL have port data_addr_ok  output  1  request accepted this cycle when high with data_req.
REQ-012 SHALL have port data_data_ok  output  1  one-cycle response pulse.
REQ-013 SHALL have port data_rdata  output  32  read word, valid with data_data_ok.

Function
REQ-014 SHALL accept a request on any cycle where data_req && data_addr_ok; accepted request performs its array access in that same cycle.
REQ-015 SHALL index array by data_addr[ADDR_WIDTH+1:2]; upper bits ignored, no fault.
REQ-016 SHALL write byte enables: size 00 -> 1<<addr[1:0]; 01 -> addr[1]?1100:0011; 10 -> 1111; 11 -> none.
REQ-017 SHALL ignore addr[0] for half and addr[1:0] for word (no alignment exception).
REQ-018 SHALL return, for reads, the full aligned 32-bit word as it stood after all earlier-accepted writes; initiator selects lanes.
REQ-019 SHALL return data_rdata = 0 for write responses and reserved-size reads still respond.
REQ-020 SHALL queue responses in a FIFO of OUTSTANDING entries {rdata, age}; responses strictly in acceptance order.
REQ-021 SHALL pulse data_data_ok for exactly one cycle when head entry age >= LATENCY, then pop it.
REQ-022 SHALL drive data_addr_ok = !full || head retiring this cycle (accept and retire simultaneously when full).
REQ-023 SHALL, with LATENCY=1, OUTSTANDING>=1, sustain one accept and one response per cycle back-to-back.
REQ-024 SHALL saturate age counters at LATENCY (no wrap).
REQ-025 SHALL keep data_addr_ok combinational from FIFO state only, never from data_req.

Reset
REQ-026 SHALL, while rst==0, drive data_addr_ok=0, data_data_ok=0, data_rdata=0, and empty the FIFO.
REQ-027 SHALL discard outstanding requests on reset mid-operation: no data_data_ok for them after reset release.
REQ-028 SHALL not reset array contents; writes accepted before reset persist.

Configuration
REQ-029 SHALL, with DATA_SRAM_STALL_EN defined, run a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) and force data_addr_ok=0 on cycles where LFSR[0]=1 and withhold head retirement where LFSR[1]=1.
REQ-030 SHALL, without DATA_SRAM_STALL_EN, contain no LFSR and behave per REQ-021/022 exactly.

Structure
REQ-031 SHALL place size encodings (SIZE_BYTE/HALF/WORD) and byte-enable function in shared package sram_like_pkg.
REQ-032 SHALL implement response queue as sub-module sram_resp_fifo (parameterised depth, push/pop/full/empty, age tracking).

Verification
REQ-033 SHALL cover: SW 0x12345678 @0x100, LW @0x100 (LATENCY=1) -> second data_ok one cycle after its accept, rdata 0x12345678.
REQ-034 SHALL cover: SB 0xAB @0x101 over word 0 -> LW @0x100 returns 0x0000AB00; SH 0xBEEF @0x102 -> 0xBEEFAB00.
REQ-035 SHALL cover: LATENCY=3, OUTSTANDING=2, data_req held high -> addr_ok low on third request until first data_ok cycle, then accepted same cycle.
REQ-036 SHALL cover: rst low while two reads outstanding -> no data_ok after release, addr_ok 1 first cycle after release.
REQ-037 SHALL cover: size 11 write @0x100 -> data_ok with rdata 0, word unchanged on following LW.
REQ-038 SHALL cover: DATA_SRAM_STALL_EN, 1000 random ops vs reference model -> all read data match, in-order responses, no lost/duplicate data_ok.
